// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Purpose  : Shared AES-128 key-schedule types, constants and GF(2^8) helpers.
//            Provides word/block types, round count, rcon start values,
//            xtime / inv_xtime (poly 0x11B), RotWord and the FSM state enum.
// Revision : 1.0  initial release
// ============================================================================
package aes_pkg;

    localparam int         NUM_ROUNDS = 10;
    localparam logic [7:0] RCON_INIT  = 8'h01;  // rcon used to derive round 1
    localparam logic [7:0] RCON_LAST  = 8'h36;  // rcon used between rounds 9 and 10

    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } ks_state_t;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Divide by x. An odd value can only come from a reduced product, so the
    // reduction is undone first: (b ^ 0x1B) >> 1 with bit 7 restored = (b>>1) ^ 0x8D.
    function automatic logic [7:0] inv_xtime(input logic [7:0] b);
        return b[0] ? ({1'b0, b[7:1]} ^ 8'h8D) : {1'b0, b[7:1]};
    endfunction

    // Cyclic left rotation by one byte.
    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/s_box_flex.sv
`default_nettype none
// ============================================================================
// Module   : s_box_flex
// Purpose  : AES forward S-box applied independently to NUM_BYTES bytes.
//            Each byte is computed as the GF(2^8) multiplicative inverse
//            (0 maps to 0) followed by the FIPS-197 affine transform.
// Ports    : plain       [8*NUM_BYTES-1:0]  input bytes
//            substituted [8*NUM_BYTES-1:0]  substituted bytes, same order
// Revision : 1.0  initial release
// ============================================================================
module s_box_flex
    import aes_pkg::*;
#(
    parameter int NUM_BYTES = 4
) (
    input  logic [8*NUM_BYTES-1:0] plain,
    output logic [8*NUM_BYTES-1:0] substituted
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] prod;
        logic [7:0] shifted;
        prod    = 8'h00;
        shifted = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                prod = prod ^ shifted;
            end
            shifted = xtime(shifted);
        end
        return prod;
    endfunction

    // a^254 = a^-1 for a != 0; 254 = 2+4+...+128, so accumulate the
    // successive squares. a = 0 naturally yields 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        logic [7:0] inv;
        inv = gf_inv(b);
        return inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
    endfunction

    generate
        for (genvar i = 0; i < NUM_BYTES; i++) begin : g_byte
            assign substituted[8*i +: 8] = sub_byte(plain[8*i +: 8]);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : key_schedule
// Purpose  : AES-128 round-key generator. On start, emits round keys 0..10
//            one per accepted valid/ready handshake, then pulses done.
//            Optional macro KEY_SCHEDULE_INVERSE_EN adds a key_dir input:
//            key_dir=1 treats cipher_key as the round-10 key and walks the
//            schedule backwards 10..0.
// Ports    : clk, n_rst (async, active-low)
//            start       begin expansion (sampled in IDLE only)
//            cipher_key  128-bit initial key, byte 0 in [127:120]
//            key_dir     direction (only with KEY_SCHEDULE_INVERSE_EN)
//            rk_ready    downstream accepts current round key
//            round_key   current round key
//            round_num   index of round_key (0..10)
//            rk_valid    round_key/round_num valid
//            busy        high whenever not IDLE
//            done        one-cycle pulse after the final round is accepted
// Revision : 1.0  initial release
// ============================================================================
module key_schedule
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic [127:0] cipher_key,
`ifdef KEY_SCHEDULE_INVERSE_EN
    input  logic         key_dir,
`endif
    input  logic         rk_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_num,
    output logic         rk_valid,
    output logic         busy,
    output logic         done
);

    ks_state_t  state;
    logic [7:0] rcon;
    word_t      w0, w1, w2, w3;
    word_t      sub_in, sub_out;
    block_t     next_key;
    logic [3:0] next_num;
    logic [7:0] next_rcon;
    logic [3:0] init_num;
    logic [7:0] init_rcon;
    logic       last_round;

    assign {w0, w1, w2, w3} = round_key;

    // Forward step: each word folds in its freshly computed left neighbour.
    word_t f0, f1, f2, f3;
    assign f0 = w0 ^ sub_out ^ {rcon, 24'h0};
    assign f1 = w1 ^ f0;
    assign f2 = w2 ^ f1;
    assign f3 = w3 ^ f2;

`ifdef KEY_SCHEDULE_INVERSE_EN
    logic  dir;   // direction captured with start
    word_t i0, i1, i2, i3;

    // Inverse step: recover the previous words right-to-left; the recovered
    // w3 feeds the S-box, so the same single S-box instance serves both ways.
    assign i3 = w3 ^ w2;
    assign i2 = w2 ^ w1;
    assign i1 = w1 ^ w0;
    assign i0 = w0 ^ sub_out ^ {rcon, 24'h0};

    assign sub_in     = dir ? rot_word(i3) : rot_word(w3);
    assign next_key   = dir ? {i0, i1, i2, i3} : {f0, f1, f2, f3};
    assign next_num   = dir ? (round_num - 4'd1) : (round_num + 4'd1);
    assign next_rcon  = dir ? inv_xtime(rcon) : xtime(rcon);
    assign last_round = dir ? (round_num == 4'd0) : (round_num == 4'(NUM_ROUNDS));
    assign init_num   = key_dir ? 4'(NUM_ROUNDS) : 4'd0;
    assign init_rcon  = key_dir ? RCON_LAST : RCON_INIT;
`else
    assign sub_in     = rot_word(w3);
    assign next_key   = {f0, f1, f2, f3};
    assign next_num   = round_num + 4'd1;
    assign next_rcon  = xtime(rcon);
    assign last_round = (round_num == 4'(NUM_ROUNDS));
    assign init_num   = 4'd0;
    assign init_rcon  = RCON_INIT;
`endif

    s_box_flex #(
        .NUM_BYTES   (4)
    ) u_s_box (
        .plain       (sub_in),
        .substituted (sub_out)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= ST_IDLE;
            round_key <= '0;
            round_num <= '0;
            rcon      <= RCON_INIT;
            rk_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef KEY_SCHEDULE_INVERSE_EN
            dir       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_ISSUE;
                        round_key <= cipher_key;
                        round_num <= init_num;
                        rcon      <= init_rcon;
                        rk_valid  <= 1'b1;
                        busy      <= 1'b1;
`ifdef KEY_SCHEDULE_INVERSE_EN
                        dir       <= key_dir;
`endif
                    end
                end
                ST_ISSUE: begin
                    // rk_valid is always high here, so rk_ready alone
                    // completes the handshake.
                    if (rk_ready) begin
                        if (last_round) begin
                            state    <= ST_DONE;
                            rk_valid <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            round_key <= next_key;
                            round_num <= next_num;
                            rcon      <= next_rcon;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    rk_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_schedule
// Purpose  : Self-checking bench for key_schedule. A word-recursive AES-128
//            expansion model (S-box built by brute-force GF inversion) gives
//            the expected round keys; randomized ready/noise stimulus.
// Revision : 1.0  initial release
// ============================================================================
module tb_key_schedule;

    logic         clk;
    logic         n_rst;
    logic         start;
    logic [127:0] cipher_key;
`ifdef KEY_SCHEDULE_INVERSE_EN
    logic         key_dir;
`endif
    logic         rk_ready;
    logic [127:0] round_key;
    logic [3:0]   round_num;
    logic         rk_valid;
    logic         busy;
    logic         done;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [7:0]   sbox [0:255];
    logic [127:0] mdl  [0:10];
    logic [127:0] seen [0:10];

    localparam logic [127:0] KAT_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    key_schedule u_dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .cipher_key (cipher_key),
`ifdef KEY_SCHEDULE_INVERSE_EN
        .key_dir    (key_dir),
`endif
        .rk_ready   (rk_ready),
        .round_key  (round_key),
        .round_num  (round_num),
        .rk_valid   (rk_valid),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int gmul(input int a, input int b);
        int p;
        int aa;
        p  = 0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (((b >> i) & 1) != 0) p = p ^ aa;
            aa = aa << 1;
            if ((aa & 'h100) != 0) aa = aa ^ 'h11B;
        end
        return p;
    endfunction

    function automatic int rotl8(input int v, input int n);
        return ((v << n) | (v >> (8 - n))) & 255;
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            int inv;
            int s;
            inv = 0;
            for (int y = 1; y < 256; y++) begin
                if (gmul(x, y) == 1) inv = y;
            end
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 'h63;
            sbox[x] = 8'(s);
        end
    endtask

    // Classic 44-word recursion; fills mdl[0..10].
    task automatic model_expand(input logic [127:0] k0);
        logic [31:0] w [0:43];
        logic [31:0] t;
        int rc;
        rc = 1;
        for (int i = 0; i < 4; i++) w[i] = k0[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
                t = t ^ 32'(rc << 24);
                rc = gmul(rc, 2);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) mdl[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_start(input logic [127:0] key, input bit dir);
        @(negedge clk);
        cipher_key = key;
`ifdef KEY_SCHEDULE_INVERSE_EN
        key_dir    = dir;
`endif
        start      = 1'b1;
        rk_ready   = 1'($urandom_range(1));
        @(negedge clk);
        start      = 1'b0;
    endtask

    // Expected keys come from mdl (indexed by round number). Returns cycles
    // from the start cycle through the done cycle inclusive.
    task automatic run_schedule(input logic [127:0] key, input bit dir, input int ready_pct,
                                input int stall_round, input bit noise, output int cycles);
        int  exp_idx;
        int  remaining;
        int  stall_cnt;
        bit  got_done;
        bit  rdy;
        exp_idx   = dir ? 10 : 0;
        remaining = 11;
        stall_cnt = 0;
        got_done  = 1'b0;
        cycles    = 0;
        do_start(key, dir);
        for (int c = 0; c < 600 && !got_done; c++) begin
            if (remaining > 0) begin
                check("rk_valid", 128'(rk_valid), 128'd1);
                check("round_num", 128'(round_num), 128'(exp_idx));
                check("round_key", round_key, mdl[exp_idx]);
                check("busy", 128'(busy), 128'd1);
                check("done_early", 128'(done), 128'd0);
                seen[exp_idx] = round_key;
            end else begin
                check("done_pulse", 128'(done), 128'd1);
                check("rk_valid_in_done", 128'(rk_valid), 128'd0);
                got_done = 1'b1;
                cycles   = c + 1;
            end
            rdy = ($urandom_range(99) < ready_pct);
            if (remaining > 0 && exp_idx == stall_round && stall_cnt < 5) begin
                rdy = 1'b0;
                stall_cnt++;
            end
            rk_ready = rdy;
            if (noise && !got_done) begin
                start      = (exp_idx == 5) ? 1'b1 : 1'($urandom_range(1));
                cipher_key = rand_key();
`ifdef KEY_SCHEDULE_INVERSE_EN
                key_dir    = 1'($urandom_range(1));
`endif
            end else begin
                start = 1'b0;
            end
            if (rdy && remaining > 0) begin
                remaining--;
                if (remaining > 0) exp_idx = dir ? exp_idx - 1 : exp_idx + 1;
            end
            if (!got_done) @(negedge clk);
        end
        if (!got_done) check("done_timeout", 128'd0, 128'd1);
        start    = 1'b0;
        rk_ready = 1'b0;
        @(negedge clk);
        check("done_cleared", 128'(done), 128'd0);
        check("busy_cleared", 128'(busy), 128'd0);
        check("rk_valid_idle", 128'(rk_valid), 128'd0);
    endtask

    initial begin
        int cyc;
        logic [127:0] k;
        n_rst      = 1'b0;
        start      = 1'b0;
        rk_ready   = 1'b0;
        cipher_key = '0;
`ifdef KEY_SCHEDULE_INVERSE_EN
        key_dir    = 1'b0;
`endif
        build_sbox();

        repeat (3) @(negedge clk);
        check("rst_round_key", round_key, 128'd0);
        check("rst_round_num", 128'(round_num), 128'd0);
        check("rst_rk_valid", 128'(rk_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        n_rst = 1'b1;
        @(negedge clk);

        // Known-answer run with ready held high
        model_expand(KAT_KEY);
        run_schedule(KAT_KEY, 1'b0, 100, -1, 1'b0, cyc);
        check("kat_round1", seen[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("kat_round10", seen[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("start_to_done_cycles", 128'(cyc), 128'd12);

        // Five-cycle stall at round 3
        run_schedule(KAT_KEY, 1'b0, 100, 3, 1'b0, cyc);
        check("stall_cycles", 128'(cyc), 128'd17);

        // start and key changes while busy (forced at round 5) are ignored
        run_schedule(KAT_KEY, 1'b0, 100, -1, 1'b1, cyc);

        // Asynchronous reset at round 6
        do_start(KAT_KEY, 1'b0);
        rk_ready = 1'b1;
        for (int c = 0; c < 30 && round_num != 4'd6; c++) @(negedge clk);
        check("reach_round6", 128'(round_num), 128'd6);
        #2 n_rst = 1'b0;
        #1;
        check("mid_rst_round_key", round_key, 128'd0);
        check("mid_rst_round_num", 128'(round_num), 128'd0);
        check("mid_rst_rk_valid", 128'(rk_valid), 128'd0);
        check("mid_rst_busy", 128'(busy), 128'd0);
        check("mid_rst_done", 128'(done), 128'd0);
        @(negedge clk);
        n_rst    = 1'b1;
        rk_ready = 1'b0;
        @(negedge clk);
        k = rand_key();
        model_expand(k);
        run_schedule(k, 1'b0, 100, -1, 1'b0, cyc);
        check("post_rst_round0", seen[0], k);

        // Random keys, random backpressure, random noise
        for (int t = 0; t < 4; t++) begin
            k = rand_key();
            model_expand(k);
            run_schedule(k, 1'b0, 50, -1, 1'b1, cyc);
        end

`ifdef KEY_SCHEDULE_INVERSE_EN
        model_expand(KAT_KEY);
        run_schedule(128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1, 100, -1, 1'b0, cyc);
        check("inv_kat_round9", seen[9], 128'hac7766f319fadc2128d12941575c006e);
        check("inv_kat_round0", seen[0], KAT_KEY);
        check("inv_cycles", 128'(cyc), 128'd12);
        for (int t = 0; t < 3; t++) begin
            k = rand_key();
            model_expand(k);
            run_schedule(mdl[10], 1'b1, 60, 7, 1'b1, cyc);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
